// File: rtl/debug_uart_tx_fifo.sv
// Debug UART transmitter with a circular transmit FIFO, a programmable baud divisor,
// 1 or 2 stop bits, sticky overflow and an end-of-frame pulse.
module debug_uart_tx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_wr_en,
    input  logic [DATA_BITS-1:0]          tx_wr_data,
    input  logic                          div_wr_en,
    input  logic [DIV_WIDTH-1:0]          div_wr_data,
    input  logic                          two_stop,
    input  logic                          ovf_clr,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          tx_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level_q;
    logic                 ovf_q;
    logic [DIV_WIDTH-1:0] div_q;

    state_t               state;
    state_t               state_next;
    logic [DIV_WIDTH-1:0] baud_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 two_stop_q;
    logic                 txd_q;
    logic                 done_q;

    logic                 push_ok;
    logic                 pop;
    logic                 bit_end;
    logic                 reload;
    logic                 shift;
    logic                 bit_inc;
    logic                 bit_clr;
    logic                 stop_set;
    logic                 txd_next;
    logic                 done_next;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == FULL_LEVEL);
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign uart_txd   = txd_q;
    assign tx_done    = done_q;
    assign tx_busy    = (state != IDLE) || !fifo_empty;

    // Fullness is the registered value, so a push into a full FIFO drops even if a pop frees a slot.
    assign push_ok = tx_wr_en && !fifo_full;
    assign bit_end = (baud_cnt == '0);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= tx_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop && !push_ok) begin
                level_q <= level_q - LVL_W'(1);
            end
            if (tx_wr_en && fifo_full) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= DIV_WIDTH'(DEFAULT_DIV);
        end else if (div_wr_en) begin
            div_q <= (div_wr_data < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bit timing: the counter reloads only at bit boundaries, so divisor writes take effect on the next bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            shreg      <= '0;
            two_stop_q <= 1'b0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            txd_q  <= txd_next;
            done_q <= done_next;
            if (reload) begin
                baud_cnt <= div_q - DIV_WIDTH'(1);
            end else if (!bit_end) begin
                baud_cnt <= baud_cnt - DIV_WIDTH'(1);
            end
            if (pop) begin
                shreg      <= mem[rd_ptr];
                two_stop_q <= two_stop;
                stop_cnt   <= 1'b0;
            end else begin
                if (shift) begin
                    shreg <= shreg >> 1;
                end
                if (stop_set) begin
                    stop_cnt <= 1'b1;
                end
            end
            if (bit_clr) begin
                bit_idx <= '0;
            end else if (bit_inc) begin
                bit_idx <= bit_idx + BIT_W'(1);
            end
        end
    end

    // Next-state logic also decides the line level for the following clock, keeping uart_txd registered.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        reload     = 1'b0;
        shift      = 1'b0;
        bit_inc    = 1'b0;
        bit_clr    = 1'b0;
        stop_set   = 1'b0;
        txd_next   = txd_q;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                txd_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    reload     = 1'b1;
                    txd_next   = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    reload     = 1'b1;
                    shift      = 1'b1;
                    bit_clr    = 1'b1;
                    txd_next   = shreg[0];
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    reload = 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        txd_next   = 1'b1;
                        state_next = STOP;
                    end else begin
                        txd_next = shreg[0];
                        shift    = 1'b1;
                        bit_inc  = 1'b1;
                    end
                end
            end
            STOP: begin
                done_next = (baud_cnt == DIV_WIDTH'(1)) && (!two_stop_q || stop_cnt);
                if (bit_end) begin
                    if (two_stop_q && !stop_cnt) begin
                        stop_set = 1'b1;
                        reload   = 1'b1;
                    end else if (!fifo_empty) begin
                        pop        = 1'b1;
                        reload     = 1'b1;
                        txd_next   = 1'b0;
                        state_next = START;
                    end else begin
                        txd_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                txd_next   = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

endmodule
